// File: rtl/gp_fetch_unit.sv
// gp_fetch_unit: instruction-fetch stage.
// Owns the PC, issues in-order requests to instruction memory, buffers returned
// 16-bit instructions with their PC in a prefetch FIFO and hands them to decode.
// A redirect flushes the FIFO and marks every in-flight response to be dropped.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   fetch_en                   allow new requests (buffer still drains when low)
//   imem_req_*                 request handshake and address to instruction memory
//   imem_rsp_valid/data        in-order response from instruction memory
//   redirect_valid/pc          branch/jump taken: flush and restart at redirect_pc
//   if_valid/instruction/pc    head of the prefetch FIFO towards decode
//   id_ready                   decode consumes the head this cycle
//   outstanding                number of requests accepted but not yet answered
//
// state | meaning
// IDLE  | fetch disabled, no requests issued
// RUN   | issuing requests while credit allows
// FLUSH | one-cycle bubble after a redirect
module gp_fetch_unit #(
    parameter int              PC_W       = 16,
    parameter logic [PC_W-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 4,
    parameter int              MAX_OUTST  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fetch_en,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [PC_W-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [15:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            if_valid,
    output logic [15:0]     if_instruction,
    output logic [PC_W-1:0] if_pc,
    input  logic            id_ready,
    output logic [2:0]      outstanding
);
    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam int QAW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CW  = FAW + 2;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
    state_t state, state_nxt;

    logic [PC_W-1:0] fetch_pc;
    logic [PC_W-1:0] rpc_mem [MAX_OUTST];
    logic [QAW-1:0]  rpc_wr, rpc_rd;
    logic [15:0]     ifq_data [FIFO_DEPTH];
    logic [PC_W-1:0] ifq_pc [FIFO_DEPTH];
    logic [FAW-1:0]  ifq_wr, ifq_rd;
    logic [FAW:0]    ifq_count;
    logic [2:0]      drop_cnt;
    logic [CW-1:0]   credit_used;
    logic            req_accept, rsp_keep, ifq_pop;

    function automatic logic [QAW-1:0] rpc_inc(input logic [QAW-1:0] p);
        return (p == QAW'(MAX_OUTST - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credit counts buffered plus in-flight entries so a response always has a slot.
    assign credit_used = CW'(ifq_count) + CW'(outstanding);

    always_comb begin
        state_nxt      = state;
        imem_req_valid = 1'b0;
        unique case (state)
            IDLE:    if (fetch_en) state_nxt = RUN;
            RUN:     if (!fetch_en) state_nxt = IDLE;
            FLUSH:   state_nxt = fetch_en ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
        if (redirect_valid) state_nxt = FLUSH;
        imem_req_valid = (state == RUN) && !redirect_valid &&
                         (credit_used < CW'(FIFO_DEPTH)) &&
                         (outstanding < 3'(MAX_OUTST));
    end

    assign imem_req_addr  = fetch_pc;
    assign req_accept     = imem_req_valid && imem_req_ready;
    // A response in the redirect cycle belongs to the old path and is dropped.
    assign rsp_keep       = imem_rsp_valid && (drop_cnt == 3'd0) && !redirect_valid;
    assign ifq_pop        = if_valid && id_ready && !redirect_valid;
    assign if_valid       = (ifq_count != '0);
    assign if_instruction = if_valid ? ifq_data[ifq_rd] : 16'h0000;
    assign if_pc          = if_valid ? ifq_pc[ifq_rd] : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            rpc_wr      <= '0;
            rpc_rd      <= '0;
            ifq_wr      <= '0;
            ifq_rd      <= '0;
            ifq_count   <= '0;
            outstanding <= 3'd0;
            drop_cnt    <= 3'd0;
        end else begin
            state <= state_nxt;

            if (redirect_valid)  fetch_pc <= redirect_pc;
            else if (req_accept) fetch_pc <= fetch_pc + 1'b1;

            if (req_accept)     rpc_wr <= rpc_inc(rpc_wr);
            if (imem_rsp_valid) rpc_rd <= rpc_inc(rpc_rd);

            unique case ({req_accept, imem_rsp_valid})
                2'b10:   outstanding <= outstanding + 3'd1;
                2'b01:   outstanding <= outstanding - 3'd1;
                default: outstanding <= outstanding;
            endcase

            if (redirect_valid)
                drop_cnt <= outstanding - {2'b00, imem_rsp_valid};
            else if (imem_rsp_valid && (drop_cnt != 3'd0))
                drop_cnt <= drop_cnt - 3'd1;

            if (redirect_valid) begin
                ifq_wr    <= '0;
                ifq_rd    <= '0;
                ifq_count <= '0;
            end else begin
                if (rsp_keep) ifq_wr <= ifq_wr + 1'b1;
                if (ifq_pop)  ifq_rd <= ifq_rd + 1'b1;
                unique case ({rsp_keep, ifq_pop})
                    2'b10:   ifq_count <= ifq_count + 1'b1;
                    2'b01:   ifq_count <= ifq_count - 1'b1;
                    default: ifq_count <= ifq_count;
                endcase
            end
        end
    end

    // Storage needs no reset: validity is tracked by the pointers and counters.
    always_ff @(posedge clk) begin
        if (req_accept) rpc_mem[rpc_wr] <= fetch_pc;
        if (rsp_keep) begin
            ifq_data[ifq_wr] <= imem_rsp_data;
            ifq_pc[ifq_wr]   <= rpc_mem[rpc_rd];
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && imem_rsp_valid) begin
            assert (outstanding != 3'd0);
            assert (!rsp_keep || (ifq_count < (FAW + 1)'(FIFO_DEPTH)));
        end
    end

endmodule

// File: tb/tb_gp_fetch_unit.sv
module tb_gp_fetch_unit;
    localparam logic [15:0] RST_PC = 16'h0010;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [15:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [15:0] imem_rsp_data;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        if_valid;
    logic [15:0] if_instruction;
    logic [15:0] if_pc;
    logic        id_ready;
    logic [2:0]  outstanding;

    gp_fetch_unit #(
        .PC_W(16), .RESET_PC(RST_PC), .FIFO_DEPTH(4), .MAX_OUTST(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .if_valid(if_valid),
        .if_instruction(if_instruction), .if_pc(if_pc),
        .id_ready(id_ready), .outstanding(outstanding)
    );

    typedef struct packed { logic [15:0] pc; logic [15:0] data; } item_t;
    typedef struct packed { int due; logic [15:0] addr; } pend_t;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          handshakes = 0;
    item_t       exp_q[$];
    logic [15:0] exp_gen_pc;
    pend_t       pend_q[$];
    logic [15:0] mem_exp_addr;
    int          mem_lat_min = 1;
    int          mem_lat_max = 1;
    int          ready_mode = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Instruction memory content: a bijection of the address.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0] ^ 8'h3C, a[15:8] ^ 8'hC3};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference stream: decode must see consecutive PCs starting at the last
    // reset/redirect target, each paired with that address's memory word.
    task automatic restart_stream(input logic [15:0] pc);
        exp_q.delete();
        exp_gen_pc   = pc;
        mem_exp_addr = pc;
    endtask

    task automatic redirect_to(input logic [15:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        restart_stream(pc);
    endtask

    initial forever begin
        @(negedge clk);
        #1;
        while (exp_q.size() < 8) begin
            exp_q.push_back('{exp_gen_pc, mem_word(exp_gen_pc)});
            exp_gen_pc++;
        end
    end

    // Memory model: configurable ready and latency, in-order responses.
    initial begin
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 16'h0000;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                pend_q.delete();
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = 16'h0000;
                imem_req_ready = 1'b1;
            end else begin
                case (ready_mode)
                    0:       imem_req_ready = 1'b1;
                    1:       imem_req_ready = ($urandom_range(0, 3) != 0);
                    default: imem_req_ready = 1'b0;
                endcase
                if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_word(pend_q[0].addr);
                    void'(pend_q.pop_front());
                end else begin
                    imem_rsp_valid = 1'b0;
                    imem_rsp_data  = 16'($urandom);
                end
            end
            #2;
            if (rst_n && imem_req_valid && imem_req_ready) begin
                chk("req_addr", imem_req_addr, mem_exp_addr);
                mem_exp_addr++;
                pend_q.push_back('{cyc + int'($urandom_range(mem_lat_min, mem_lat_max)), imem_req_addr});
            end
        end
    end

    // Decode-side monitor / scoreboard.
    initial forever begin
        item_t e;
        @(negedge clk);
        #3;
        if (rst_n && !redirect_valid && if_valid && id_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard_empty: got pc %0h with nothing expected", if_pc);
            end else begin
                e = exp_q.pop_front();
                chk("if_pc", if_pc, e.pc);
                chk("if_instruction", if_instruction, e.data);
                handshakes++;
            end
        end
        if (rst_n && !if_valid) chk("nop_when_empty", if_instruction, 16'h0000);
    end

    initial begin
        int          first_acc, first_v, bubbles, hold_err, hs0;
        logic [15:0] hold_pc, hold_ins, h_addr;
        logic [2:0]  h_out;
        logic        saw_ffff, wrap_done;

        rst_n = 1'b0; fetch_en = 1'b0; id_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 16'h0000;
        restart_stream(RST_PC);
        repeat (2) @(negedge clk);
        #3;
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_if_valid", if_valid, 0);
        chk("rst_if_instruction", if_instruction, 0);
        chk("rst_if_pc", if_pc, 0);
        chk("rst_outstanding", outstanding, 0);

        // Reset release, 1-cycle memory, latency and bubble-free streaming.
        @(negedge clk);
        rst_n = 1'b1; fetch_en = 1'b1; id_ready = 1'b1;
        first_acc = -1; first_v = -1;
        for (int i = 0; i < 12; i++) begin
            #3;
            if (first_acc < 0 && imem_req_valid && imem_req_ready) begin
                first_acc = cyc;
                chk("first_req_addr", imem_req_addr, RST_PC);
            end
            if (first_v < 0 && if_valid) begin
                first_v = cyc;
                chk("first_if_pc", if_pc, RST_PC);
            end
            @(negedge clk);
        end
        chk("first_latency", first_v - first_acc, 2);
        bubbles = 0;
        for (int i = 0; i < 15; i++) begin
            #3;
            if (!if_valid) bubbles++;
            @(negedge clk);
        end
        chk("no_bubbles", bubbles, 0);

        // Decode stall: outputs hold, requests stop once credit is used up.
        id_ready = 1'b0;
        #3;
        chk("stall_start_valid", if_valid, 1);
        hold_pc = if_pc; hold_ins = if_instruction; hold_err = 0;
        for (int i = 1; i < 10; i++) begin
            @(negedge clk);
            #3;
            if (if_pc !== hold_pc || if_instruction !== hold_ins || !if_valid) hold_err++;
        end
        chk("stall_hold", hold_err, 0);
        chk("stall_req_stopped", imem_req_valid, 0);
        chk("stall_outstanding", outstanding, 0);
        @(negedge clk);
        id_ready = 1'b1;
        repeat (10) @(negedge clk);

        // 3-cycle memory, redirect with requests in flight.
        mem_lat_min = 3; mem_lat_max = 3;
        for (int i = 0; i < 20; i++) begin
            #3;
            if (outstanding == 3'd3) break;
            @(negedge clk);
        end
        chk("outstanding_3", outstanding, 3);
        @(negedge clk);
        redirect_to(16'h0040);
        #3;
        chk("no_req_in_redirect", imem_req_valid, 0);
        @(negedge clk);
        redirect_valid = 1'b0;
        mem_lat_min = 1; mem_lat_max = 1;
        #3;
        chk("no_req_in_flush", imem_req_valid, 0);
        chk("flush_if_valid", if_valid, 0);
        @(negedge clk);
        #3;
        chk("req_valid_after_flush", imem_req_valid, 1);
        chk("req_addr_after_flush", imem_req_addr, 16'h0040);
        for (int i = 0; i < 20; i++) begin
            if (if_valid) break;
            @(negedge clk);
            #3;
        end
        chk("first_pc_after_redirect", if_pc, 16'h0040);
        @(negedge clk);
        repeat (8) @(negedge clk);

        // Redirect coinciding with a response and an accepted head.
        redirect_to(16'h0100);
        #3;
        chk("pre_redirect_if_valid", if_valid, 1);
        @(negedge clk);
        redirect_valid = 1'b0;
        #3;
        chk("coincide_if_valid", if_valid, 0);
        chk("coincide_outstanding", outstanding, 0);
        @(negedge clk);
        #3;
        chk("coincide_req_addr", imem_req_addr, 16'h0100);
        @(negedge clk);
        repeat (6) @(negedge clk);

        // PC wrap from 0xFFFF to 0x0000.
        redirect_to(16'hFFFE);
        @(negedge clk);
        redirect_valid = 1'b0;
        saw_ffff = 1'b0; wrap_done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #3;
            if (!wrap_done && imem_req_valid && imem_req_ready) begin
                if (saw_ffff) begin
                    chk("wrap_addr", imem_req_addr, 16'h0000);
                    wrap_done = 1'b1;
                end else if (imem_req_addr == 16'hFFFF) begin
                    saw_ffff = 1'b1;
                end
            end
            @(negedge clk);
        end
        chk("wrap_seen", wrap_done, 1);

        // Memory not ready: address and outstanding hold.
        ready_mode = 2;
        @(negedge clk);
        #3;
        h_addr = imem_req_addr; h_out = outstanding; hold_err = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #3;
            if (imem_req_addr !== h_addr || outstanding !== h_out || !imem_req_valid) hold_err++;
        end
        chk("ready_low_hold", hold_err, 0);
        chk("ready_low_valid", imem_req_valid, 1);

        // One-cycle reset mid-stream.
        @(negedge clk);
        rst_n = 1'b0; ready_mode = 0;
        restart_stream(RST_PC);
        @(negedge clk);
        rst_n = 1'b1;
        #3;
        chk("mid_rst_req_valid", imem_req_valid, 0);
        chk("mid_rst_if_valid", if_valid, 0);
        chk("mid_rst_if_instruction", if_instruction, 0);
        chk("mid_rst_if_pc", if_pc, 0);
        chk("mid_rst_outstanding", outstanding, 0);
        @(negedge clk);
        #3;
        chk("mid_rst_restart_valid", imem_req_valid, 1);
        chk("mid_rst_restart_addr", imem_req_addr, RST_PC);
        @(negedge clk);

        // Randomized traffic with random redirects and fetch_en toggling.
        ready_mode = 1; mem_lat_min = 1; mem_lat_max = 4;
        hs0 = handshakes;
        for (int i = 0; i < 3000; i++) begin
            id_ready = ($urandom_range(0, 3) != 0);
            fetch_en = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 24) == 0) redirect_to(16'($urandom));
            else redirect_valid = 1'b0;
            @(negedge clk);
        end
        redirect_valid = 1'b0; fetch_en = 1'b1; id_ready = 1'b1;
        repeat (20) @(negedge clk);
        #3;
        chk("random_progress", (handshakes - hs0) > 300, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
